zoom_sequencer: RTL and testbench
=================================

Name: zoom_sequencer

Overview:
- Parametrised successor to the two-button zoom/algorithm selector. Cycles through NUM_ALGS scaling algorithms and tracks a signed zoom level over several enlarge/reduce steps. Conditions raw active-low push-buttons.
- Drives a START/DONE handshake to the scaling coprocessor. A request runs only when the resulting level stays in range. Sits between the board buttons and the coprocessor command path.

Parameters:
- NUM_ALGS, 4, number of algorithms (>=2); ALG_W = clog2(NUM_ALGS).
- NUM_ENLARGE, 2, algorithm codes 0..NUM_ENLARGE-1 enlarge, the remaining codes reduce.
- MAX_ENL, 2, maximum zoom level (enlarge steps above default).
- MAX_RED, 2, maximum reduce steps below default (level floor = -MAX_RED).
- LVL_W, 4, width of signed ZOOM_LEVEL; must hold -MAX_RED..+MAX_ENL.
- DEBOUNCE_CYCLES, 50000, number of stable cycles required before a button change is accepted.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- BTN_ALG  in  1  raw active-low button; each press advances ALGORITHM.
- BTN_APPLY  in  1  raw active-low button; each press requests one scaling step with ALGORITHM.
- DONE  in  1  one-cycle pulse from the coprocessor ending the current operation.
- ALGORITHM  out  ALG_W  currently selected algorithm.
- OP_ALG  out  ALG_W  algorithm latched for the operation in flight.
- START  out  1  one-cycle command pulse to the coprocessor.
- BUSY  out  1  high from the START cycle until the cycle DONE is accepted.
- REJECT  out  1  one-cycle pulse when an apply request would leave the level range.
- ZOOM_LEVEL  out  LVL_W  signed committed zoom level.
- IMAGE_STATE  out  2  0 = default (level 0), 1 = enlarged (>0), 2 = reduced (<0); 3 is never driven.

Behaviour:
- Reset (async assert, sync release): ALGORITHM=0, OP_ALG=0, START=0, BUSY=0, REJECT=0, ZOOM_LEVEL=0, IMAGE_STATE=0, FSM=IDLE. Debounced button state = released (1); no press event is generated on reset release.
- Button conditioning, per button:
  - 2-flop synchroniser, then a stability counter.
  - The debounced value updates only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce resets the counter.
  - A press event is a one-cycle pulse on a debounced 1->0 transition. Release generates nothing.
  - Latency from a stable raw press to the event is 2 + DEBOUNCE_CYCLES cycles, ±1.
- Algorithm select:
  - On an ALG press, ALGORITHM <= ALGORITHM+1, wrapping from NUM_ALGS-1 to 0 (non-power-of-2 NUM_ALGS included).
  - Accepted in every FSM state; OP_ALG protects the operation in flight.
- FSM IDLE -> START_ST -> WAIT -> IDLE.
  - IDLE, APPLY press: compute target = ZOOM_LEVEL+1 when ALGORITHM < NUM_ENLARGE, else ZOOM_LEVEL-1.
  - If target > MAX_ENL or target < -MAX_RED: pulse REJECT next cycle and stay in IDLE; level is unchanged.
  - Otherwise, next cycle: OP_ALG <= ALGORITHM, START=1, BUSY=1, go to START_ST.
  - START_ST lasts exactly one cycle (START high); then START=0, go to WAIT.
  - WAIT: BUSY stays high. On DONE, ZOOM_LEVEL <= target and IMAGE_STATE follows in the same edge. BUSY drops next cycle; go to IDLE.
- DONE is sampled only in WAIT; DONE in IDLE or START_ST is ignored.
- APPLY presses while BUSY are dropped: no queuing and no REJECT.
- ALG and APPLY press in the same cycle: the apply uses the pre-increment ALGORITHM; ALGORITHM still increments.
- Level stepping is ±1 saturating and symmetric. An enlarge step from reduced moves toward default; a reduce step from enlarged moves toward default.
- RESET_N asserted mid-operation aborts immediately to the reset values. A later DONE is ignored.
- IMAGE_STATE is a registered function of the committed ZOOM_LEVEL and never reflects the pending target.

Decomposition:
- Shared package zoom_pkg:
  - IMAGE_STATE encodings: ST_DEFAULT=0, ST_ENLARGED=1, ST_REDUCED=2.
  - Algorithm codes: ALG_NN=0, ALG_PR=1, ALG_DC=2, ALG_BA=3.
  - FSM state encoding.
- Sub-module button_conditioner (parameter DEBOUNCE_CYCLES; ports CLK, RESET_N, BTN_N, PRESS), instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4, defaults otherwise):
- ALG held low for 10 cycles, then released, repeated 5 times -> ALGORITHM 1,2,3,0,1. A glitch of 3 cycles low produces no change.
- ALGORITHM=0, APPLY press -> one-cycle START with OP_ALG=0, BUSY high. DONE 5 cycles later -> ZOOM_LEVEL=1, IMAGE_STATE=1, BUSY low next cycle.
- Three enlarge applies, each completed with DONE -> levels 1, 2, then the third gives REJECT pulse with no START; level stays 2.
- Select ALGORITHM=2 at level 2, apply twice -> levels 1, 0 (IMAGE_STATE 1 then 0). Apply twice more -> -1, -2 (state 2). Fifth apply -> REJECT.
- APPLY press during WAIT -> no START and no REJECT; DONE before START (in IDLE) -> no level change.
- RESET_N low during WAIT -> all outputs at reset values immediately. DONE after release -> ZOOM_LEVEL stays 0.

Source files
------------

// File: rtl/zoom_pkg.sv
// Shared encodings for the zoom sequencer: image state, algorithm codes and FSM states.
package zoom_pkg;

    typedef enum logic [1:0] {
        ST_DEFAULT  = 2'd0,
        ST_ENLARGED = 2'd1,
        ST_REDUCED  = 2'd2
    } image_state_e;

    localparam int ALG_NN = 0;
    localparam int ALG_PR = 1;
    localparam int ALG_DC = 2;
    localparam int ALG_BA = 3;

    typedef enum logic [1:0] {
        FSM_IDLE  = 2'd0,
        FSM_START = 2'd1,
        FSM_WAIT  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/button_conditioner.sv
// Synchronises and debounces one raw active-low button; pulses PRESS on a debounced press.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic BTN_N,
    output logic PRESS
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = deb_q & ~deb_d;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= BTN_N;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign PRESS = press_q;

endmodule

// File: rtl/zoom_sequencer.sv
// Button-driven algorithm selector and zoom-level tracker with a START/DONE coprocessor handshake.
module zoom_sequencer
    import zoom_pkg::*;
#(
    parameter int NUM_ALGS        = 4,
    parameter int NUM_ENLARGE     = 2,
    parameter int MAX_ENL         = 2,
    parameter int MAX_RED         = 2,
    parameter int LVL_W           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    localparam int ALG_W          = $clog2(NUM_ALGS)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             BTN_ALG,
    input  logic             BTN_APPLY,
    input  logic             DONE,
    output logic [ALG_W-1:0] ALGORITHM,
    output logic [ALG_W-1:0] OP_ALG,
    output logic             START,
    output logic             BUSY,
    output logic             REJECT,
    output logic [LVL_W-1:0] ZOOM_LEVEL,
    output logic [1:0]       IMAGE_STATE
);

    localparam logic [ALG_W-1:0] ALG_LAST = ALG_W'(NUM_ALGS - 1);

    logic alg_press, apply_press;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_alg (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .BTN_N   (BTN_ALG),
        .PRESS   (alg_press)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_apply (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .BTN_N   (BTN_APPLY),
        .PRESS   (apply_press)
    );

    seq_state_e              state_q, state_d;
    logic        [ALG_W-1:0] alg_q, alg_d;
    logic        [ALG_W-1:0] op_alg_q, op_alg_d;
    logic                    start_q, start_d;
    logic                    busy_q, busy_d;
    logic                    reject_q, reject_d;
    logic signed [LVL_W-1:0] level_q, level_d;
    logic signed [LVL_W-1:0] target_q, target_d;
    image_state_e            img_q, img_d;
    int                      tgt;

    always_comb begin
        state_d  = state_q;
        alg_d    = alg_q;
        op_alg_d = op_alg_q;
        start_d  = 1'b0;
        busy_d   = busy_q;
        reject_d = 1'b0;
        level_d  = level_q;
        target_d = target_q;

        if (alg_press) begin
            alg_d = (alg_q == ALG_LAST) ? '0 : alg_q + 1'b1;
        end

        // Range check in full int width so the step cannot wrap inside LVL_W bits.
        tgt = (int'(alg_q) < NUM_ENLARGE) ? int'(level_q) + 1 : int'(level_q) - 1;

        case (state_q)
            FSM_IDLE: begin
                if (apply_press) begin
                    if (tgt > MAX_ENL || tgt < -MAX_RED) begin
                        reject_d = 1'b1;
                    end else begin
                        op_alg_d = alg_q;
                        start_d  = 1'b1;
                        busy_d   = 1'b1;
                        target_d = LVL_W'(tgt);
                        state_d  = FSM_START;
                    end
                end
            end
            FSM_START: state_d = FSM_WAIT;
            FSM_WAIT: begin
                if (DONE) begin
                    level_d = target_q;
                    busy_d  = 1'b0;
                    state_d = FSM_IDLE;
                end
            end
            default: state_d = FSM_IDLE;
        endcase

        if (level_d == '0) begin
            img_d = ST_DEFAULT;
        end else if (level_d[LVL_W-1]) begin
            img_d = ST_REDUCED;
        end else begin
            img_d = ST_ENLARGED;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= FSM_IDLE;
            alg_q    <= '0;
            op_alg_q <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            reject_q <= 1'b0;
            level_q  <= '0;
            target_q <= '0;
            img_q    <= ST_DEFAULT;
        end else begin
            state_q  <= state_d;
            alg_q    <= alg_d;
            op_alg_q <= op_alg_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            reject_q <= reject_d;
            level_q  <= level_d;
            target_q <= target_d;
            img_q    <= img_d;
        end
    end

    assign ALGORITHM   = alg_q;
    assign OP_ALG      = op_alg_q;
    assign START       = start_q;
    assign BUSY        = busy_q;
    assign REJECT      = reject_q;
    assign ZOOM_LEVEL  = level_q;
    assign IMAGE_STATE = img_q;

endmodule

// File: tb/tb_zoom_sequencer.sv
// Self-checking bench for zoom_sequencer against a simple level/algorithm reference model.
module tb_zoom_sequencer;
    import zoom_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       BTN_ALG;
    logic       BTN_APPLY;
    logic       DONE;
    logic [1:0] ALGORITHM;
    logic [1:0] OP_ALG;
    logic       START;
    logic       BUSY;
    logic       REJECT;
    logic [3:0] ZOOM_LEVEL;
    logic [1:0] IMAGE_STATE;

    zoom_sequencer #(
        .NUM_ALGS(4), .NUM_ENLARGE(2), .MAX_ENL(2), .MAX_RED(2),
        .LVL_W(4), .DEBOUNCE_CYCLES(4)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .BTN_ALG(BTN_ALG), .BTN_APPLY(BTN_APPLY),
        .DONE(DONE), .ALGORITHM(ALGORITHM), .OP_ALG(OP_ALG), .START(START),
        .BUSY(BUSY), .REJECT(REJECT), .ZOOM_LEVEL(ZOOM_LEVEL), .IMAGE_STATE(IMAGE_STATE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passes = 0;
    int start_cnt = 0;
    int reject_cnt = 0;

    // reference model state
    int m_alg = 0;
    int m_level = 0;
    int m_pending = 0;

    always begin
        @(negedge CLK);
        #2;
        if (START === 1'b1) start_cnt++;
        if (REJECT === 1'b1) reject_cnt++;
    end

    function automatic int exp_img(input int lvl);
        if (lvl == 0) return 0;
        else if (lvl > 0) return 1;
        else return 2;
    endfunction

    function automatic int lvl_now();
        return int'($signed(ZOOM_LEVEL));
    endfunction

    task automatic test_reset();
        RESET_N = 1'b0; BTN_ALG = 1'b1; BTN_APPLY = 1'b1; DONE = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({ALGORITHM, OP_ALG, START, BUSY, REJECT, ZOOM_LEVEL, IMAGE_STATE} !== 13'd0)
            $display("FAIL reset: outputs=%b required all zero",
                     {ALGORITHM, OP_ALG, START, BUSY, REJECT, ZOOM_LEVEL, IMAGE_STATE});
        else passes++;
        RESET_N = 1'b1;
        repeat (10) @(negedge CLK);
        checks++;
        if (ALGORITHM !== 2'd0 || start_cnt != 0 || reject_cnt != 0)
            $display("FAIL reset_release: alg=%0d starts=%0d rejects=%0d required 0/0/0",
                     ALGORITHM, start_cnt, reject_cnt);
        else passes++;
    endtask

    task automatic test_alg_press();
        BTN_ALG = 1'b0;
        repeat (10) @(negedge CLK);
        BTN_ALG = 1'b1;
        repeat (10) @(negedge CLK);
        m_alg = (m_alg + 1) % 4;
        checks++;
        if (int'(ALGORITHM) !== m_alg)
            $display("FAIL alg_press: ALGORITHM=%0d required %0d", ALGORITHM, m_alg);
        else passes++;
    endtask

    task automatic test_glitch();
        BTN_ALG = 1'b0;
        repeat (3) @(negedge CLK);
        BTN_ALG = 1'b1;
        repeat (10) @(negedge CLK);
        checks++;
        if (int'(ALGORITHM) !== m_alg)
            $display("FAIL glitch: ALGORITHM=%0d required %0d", ALGORITHM, m_alg);
        else passes++;
    endtask

    task automatic do_apply(input int done_delay, input bit send_done, input bit with_alg,
                            input string tag);
        int s0, r0, opa, tgt;
        bit acc;
        opa = m_alg;
        tgt = m_level + ((m_alg < 2) ? 1 : -1);
        acc = (tgt <= 2) && (tgt >= -2);
        s0 = start_cnt;
        r0 = reject_cnt;
        BTN_APPLY = 1'b0;
        if (with_alg) BTN_ALG = 1'b0;
        repeat (10) @(negedge CLK);
        BTN_APPLY = 1'b1;
        BTN_ALG = 1'b1;
        repeat (8) @(negedge CLK);
        if (with_alg) begin
            m_alg = (m_alg + 1) % 4;
            checks++;
            if (int'(ALGORITHM) !== m_alg)
                $display("FAIL %s alg_inc: ALGORITHM=%0d required %0d", tag, ALGORITHM, m_alg);
            else passes++;
        end
        checks++;
        if (start_cnt - s0 != (acc ? 1 : 0) || reject_cnt - r0 != (acc ? 0 : 1))
            $display("FAIL %s pulses: start=%0d reject=%0d required %0d/%0d",
                     tag, start_cnt - s0, reject_cnt - r0, acc ? 1 : 0, acc ? 0 : 1);
        else passes++;
        checks++;
        if (lvl_now() != m_level || int'(IMAGE_STATE) != exp_img(m_level))
            $display("FAIL %s pending: level=%0d state=%0d required %0d/%0d",
                     tag, lvl_now(), IMAGE_STATE, m_level, exp_img(m_level));
        else passes++;
        if (acc) begin
            checks++;
            if (BUSY !== 1'b1 || int'(OP_ALG) !== opa)
                $display("FAIL %s busy_opalg: busy=%b op_alg=%0d required 1/%0d",
                         tag, BUSY, OP_ALG, opa);
            else passes++;
            m_pending = tgt;
            if (send_done) begin
                repeat (done_delay) @(negedge CLK);
                DONE = 1'b1;
                @(negedge CLK);
                DONE = 1'b0;
                m_level = tgt;
                checks++;
                if (lvl_now() != m_level || int'(IMAGE_STATE) != exp_img(m_level) || BUSY !== 1'b0)
                    $display("FAIL %s done: level=%0d state=%0d busy=%b required %0d/%0d/0",
                             tag, lvl_now(), IMAGE_STATE, BUSY, m_level, exp_img(m_level));
                else passes++;
            end
        end
    endtask

    task automatic test_enlarge_saturate();
        while (m_alg != ALG_NN) test_alg_press();
        do_apply(5, 1'b1, 1'b0, "enl1");
        do_apply(2, 1'b1, 1'b0, "enl2");
        do_apply(0, 1'b1, 1'b0, "enl3_reject");
    endtask

    task automatic test_reduce_saturate();
        while (m_alg != ALG_DC) test_alg_press();
        for (int i = 0; i < 5; i++) do_apply(i, 1'b1, 1'b0, "reduce");
    endtask

    task automatic test_busy_drop();
        int s0, r0;
        while (m_alg != ALG_PR) test_alg_press();
        do_apply(0, 1'b0, 1'b0, "busy_first");
        s0 = start_cnt;
        r0 = reject_cnt;
        BTN_APPLY = 1'b0;
        repeat (10) @(negedge CLK);
        BTN_APPLY = 1'b1;
        repeat (8) @(negedge CLK);
        checks++;
        if (start_cnt != s0 || reject_cnt != r0 || BUSY !== 1'b1)
            $display("FAIL busy_drop: start=%0d reject=%0d busy=%b required 0/0/1",
                     start_cnt - s0, reject_cnt - r0, BUSY);
        else passes++;
        DONE = 1'b1;
        @(negedge CLK);
        DONE = 1'b0;
        m_level = m_pending;
        checks++;
        if (lvl_now() != m_level || BUSY !== 1'b0)
            $display("FAIL busy_done: level=%0d busy=%b required %0d/0", lvl_now(), BUSY, m_level);
        else passes++;
    endtask

    task automatic test_done_idle();
        int s0;
        s0 = start_cnt;
        DONE = 1'b1;
        @(negedge CLK);
        DONE = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (lvl_now() != m_level || BUSY !== 1'b0 || start_cnt != s0)
            $display("FAIL done_idle: level=%0d busy=%b required %0d/0", lvl_now(), BUSY, m_level);
        else passes++;
    endtask

    task automatic test_simultaneous();
        while (m_alg != ALG_BA) test_alg_press();
        // level is reachable by a reduce step only if above the floor
        if (m_level == -2) begin
            test_alg_press();
            do_apply(1, 1'b1, 1'b0, "sim_prep");
            test_alg_press(); test_alg_press(); test_alg_press();
        end
        do_apply(1, 1'b1, 1'b1, "simultaneous");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 2) == 0) test_alg_press();
            else do_apply(int'($urandom_range(0, 6)), 1'b1, $urandom_range(0, 3) == 0, "random");
        end
    endtask

    task automatic test_reset_mid_op();
        int s0;
        if (m_level > 0) begin
            while (m_alg < 2) test_alg_press();
        end else begin
            while (m_alg >= 2) test_alg_press();
        end
        do_apply(0, 1'b0, 1'b0, "rst_prep");
        repeat (2) @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        m_alg = 0;
        m_level = 0;
        checks++;
        if ({ALGORITHM, OP_ALG, START, BUSY, REJECT, ZOOM_LEVEL, IMAGE_STATE} !== 13'd0)
            $display("FAIL reset_mid_op: outputs=%b required all zero",
                     {ALGORITHM, OP_ALG, START, BUSY, REJECT, ZOOM_LEVEL, IMAGE_STATE});
        else passes++;
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
        s0 = start_cnt;
        DONE = 1'b1;
        @(negedge CLK);
        DONE = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (lvl_now() != 0 || int'(IMAGE_STATE) != 0 || BUSY !== 1'b0 || start_cnt != s0)
            $display("FAIL done_after_reset: level=%0d state=%0d busy=%b required 0/0/0",
                     lvl_now(), IMAGE_STATE, BUSY);
        else passes++;
    endtask

    initial begin
        test_reset();
        for (int i = 0; i < 5; i++) test_alg_press();
        test_glitch();
        test_enlarge_saturate();
        test_reduce_saturate();
        test_busy_drop();
        test_done_idle();
        test_simultaneous();
        test_random();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, required finish");
        $fatal(1);
    end

endmodule
